pipe_stream_checker: RTL and testbench

Parametrised pattern source/sink for host pipe benchmarking and integrity test, in the ti_clk domain next to the okBTPipeIn/okBTPipeOut endpoints.
- Generalises the earlier fixed 16-bit in-checker/out-generator pair into one block with:
  - configurable data width;
  - three pattern modes;
  - independent block-throttles per direction;
  - saturating error counting, first-error capture, and per-direction word counters.

---
 rtl/pipe_stream_checker.sv | 212 +++++++++++++++++++++
 tb/tb_pipe_stream_checker.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stream_checker.sv
// pipe_stream_checker
//   Pattern source/sink for host pipe benchmarking and integrity test, in the
//   ti_clk domain beside the okBTPipeIn/okBTPipeOut endpoints. One generator
//   drives pipe_out_data and a second one predicts pipe_in_data. Each has
//   three pattern modes. A rotating throttle pattern per direction drives the
//   advisory block-ready outputs.
//
// Parameters
//   DATA_W  pipe word width (16, 32 or 64)
//   ERR_W   error counter width
//   THR_W   throttle rotate-register width
//   SEED    LFSR seed (non-zero)
//
// Ports
//   clk, reset_n                      endpoint clock, synchronous active-low reset
//   mode                              00 counter, 01 LFSR, 10 walking-ones, 11 = 00
//   throttle_set                      load both throttle registers
//   throttle_in_val/throttle_out_val  throttle patterns
//   pipe_in_write/pipe_in_data        incoming word strobe and data
//   pipe_in_ready                     pipe-in block-ready (advisory)
//   pipe_out_read                     outgoing word strobe
//   pipe_out_data                     current outgoing word (registered)
//   pipe_out_ready                    pipe-out block-ready (advisory)
//   error_count                       saturating mismatch count
//   first_err_valid/_exp/_act         capture of the first mismatch
//   words_in/words_out                wrapping word counters
//   inject_err                        only when PIPE_STREAM_ERR_INJECT_EN is defined:
//                                     arms a one-shot that flips bit 0 of the
//                                     next word loaded onto pipe_out_data
module pipe_stream_checker #(
   parameter int          DATA_W = 16,
   parameter int          ERR_W  = 16,
   parameter int          THR_W  = 32,
   parameter logic [31:0] SEED   = 32'h0000_0001
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        mode,
   input  logic              throttle_set,
   input  logic [THR_W-1:0]  throttle_in_val,
   input  logic [THR_W-1:0]  throttle_out_val,
   input  logic              pipe_in_write,
   input  logic [DATA_W-1:0] pipe_in_data,
   output logic              pipe_in_ready,
   input  logic              pipe_out_read,
   output logic [DATA_W-1:0] pipe_out_data,
   output logic              pipe_out_ready,
`ifdef PIPE_STREAM_ERR_INJECT_EN
   input  logic              inject_err,
`endif
   output logic [ERR_W-1:0]  error_count,
   output logic              first_err_valid,
   output logic [DATA_W-1:0] first_err_exp,
   output logic [DATA_W-1:0] first_err_act,
   output logic [31:0]       words_in,
   output logic [31:0]       words_out
);

   typedef enum logic [1:0] {
      MODE_CNT  = 2'b00,
      MODE_LFSR = 2'b01,
      MODE_WALK = 2'b10,
      MODE_RSVD = 2'b11
   } mode_t;

   localparam logic [DATA_W-1:0] WALK0 = DATA_W'(1);

   // Fibonacci LFSR, x^32 + x^22 + x^2 + x + 1
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   // For 16/32 bits the low slice of {~state, state} is the plain state.
   function automatic logic [DATA_W-1:0] pattern(input mode_t m,
                                                 input logic [DATA_W-1:0] c,
                                                 input logic [31:0] l,
                                                 input logic [DATA_W-1:0] w);
      logic [63:0] wide;
      wide = {~l, l};
      case (m)
         MODE_LFSR: return wide[DATA_W-1:0];
         MODE_WALK: return w;
         default:   return c;
      endcase
   endfunction

   mode_t             mode_q;
   logic [DATA_W-1:0] in_cnt, out_cnt;
   logic [31:0]       in_lfsr, out_lfsr;
   logic [DATA_W-1:0] in_walk, out_walk;
   logic [THR_W-1:0]  thr_in, thr_out;

   logic              mode_chg;
   logic [DATA_W-1:0] exp_word;
   logic [DATA_W-1:0] seed_word;
   logic [DATA_W-1:0] out_cnt_nxt;
   logic [31:0]       out_lfsr_nxt;
   logic [DATA_W-1:0] out_walk_nxt;
   logic              out_load;
   logic [DATA_W-1:0] out_word_nxt;
   logic [DATA_W-1:0] inj_mask;

   always_comb begin
      mode_chg     = (mode != mode_q);
      exp_word     = pattern(mode_q, in_cnt, in_lfsr, in_walk);
      seed_word    = pattern(mode_t'(mode), '0, SEED, WALK0);
      out_cnt_nxt  = out_cnt + DATA_W'(1);
      out_lfsr_nxt = lfsr_step(out_lfsr);
      out_walk_nxt = {out_walk[DATA_W-2:0], out_walk[DATA_W-1]};
      out_load     = mode_chg | pipe_out_read;
      // A mode change reloads word 0 of the new mode even under a read:
      // the read takes the old word, the next one is the new mode's word 0.
      if (mode_chg)
         out_word_nxt = seed_word;
      else
         out_word_nxt = pattern(mode_q, out_cnt_nxt, out_lfsr_nxt, out_walk_nxt);
   end

`ifdef PIPE_STREAM_ERR_INJECT_EN
   logic inj_armed;

   always_comb begin
      inj_mask = '0;
      inj_mask[0] = inj_armed;
   end

   // The one-shot corrupts only the output register, never generator state.
   always_ff @(posedge clk) begin
      if (!reset_n)
         inj_armed <= 1'b0;
      else if (out_load)
         inj_armed <= inject_err;
      else if (inject_err)
         inj_armed <= 1'b1;
   end
`else
   always_comb inj_mask = '0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mode_q          <= mode_t'(mode);
         in_cnt          <= '0;
         in_lfsr         <= SEED;
         in_walk         <= WALK0;
         out_cnt         <= '0;
         out_lfsr        <= SEED;
         out_walk        <= WALK0;
         pipe_out_data   <= seed_word;
         thr_in          <= '1;
         thr_out         <= '1;
         pipe_in_ready   <= 1'b0;
         pipe_out_ready  <= 1'b0;
         error_count     <= '0;
         first_err_valid <= 1'b0;
         first_err_exp   <= '0;
         first_err_act   <= '0;
         words_in        <= '0;
         words_out       <= '0;
      end else begin
         // throttle: ready follows the MSB one cycle later
         pipe_in_ready  <= thr_in[THR_W-1];
         pipe_out_ready <= thr_out[THR_W-1];
         thr_in  <= throttle_set ? throttle_in_val  : {thr_in[THR_W-2:0],  thr_in[THR_W-1]};
         thr_out <= throttle_set ? throttle_out_val : {thr_out[THR_W-2:0], thr_out[THR_W-1]};

         mode_q <= mode_t'(mode);

         // pipe-in: compared against the current (pre-change) expected word
         if (pipe_in_write) begin
            words_in <= words_in + 32'd1;
            if (pipe_in_data != exp_word) begin
               if (error_count != '1)
                  error_count <= error_count + ERR_W'(1);
               if (!first_err_valid) begin
                  first_err_valid <= 1'b1;
                  first_err_exp   <= exp_word;
                  first_err_act   <= pipe_in_data;
               end
            end
         end

         if (mode_chg) begin
            in_cnt  <= '0;
            in_lfsr <= SEED;
            in_walk <= WALK0;
         end else if (pipe_in_write) begin
            in_cnt  <= in_cnt + DATA_W'(1);
            in_lfsr <= lfsr_step(in_lfsr);
            in_walk <= {in_walk[DATA_W-2:0], in_walk[DATA_W-1]};
         end

         // pipe-out
         if (pipe_out_read)
            words_out <= words_out + 32'd1;

         if (mode_chg) begin
            out_cnt  <= '0;
            out_lfsr <= SEED;
            out_walk <= WALK0;
         end else if (pipe_out_read) begin
            out_cnt  <= out_cnt_nxt;
            out_lfsr <= out_lfsr_nxt;
            out_walk <= out_walk_nxt;
         end

         if (out_load)
            pipe_out_data <= out_word_nxt ^ inj_mask;
      end
   end

endmodule

// File: tb/tb_pipe_stream_checker.sv
module tb_pipe_stream_checker;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic        throttle_set = 1'b0;
   logic [31:0] thr_in_val = '1;
   logic [31:0] thr_out_val = '1;
`ifdef PIPE_STREAM_ERR_INJECT_EN
   logic        inject_err = 1'b0;
`endif

   // 16-bit instance with a 4-bit error counter
   logic        rd16 = 1'b0, wr16 = 1'b0;
   logic [15:0] din16 = '0;
   logic [15:0] dout16, fexp16, fact16;
   logic        in_rdy16, out_rdy16, fev16;
   logic [3:0]  err16;
   logic [31:0] win16, wout16;

   // 64-bit instance
   logic        rd64 = 1'b0, wr64 = 1'b0;
   logic [63:0] din64 = '0;
   logic [63:0] dout64, fexp64, fact64;
   logic        in_rdy64, out_rdy64, fev64;
   logic [15:0] err64;
   logic [31:0] win64, wout64;

   int vec = 0;
   int miss = 0;
   logic [31:0] lseq [0:1100];

   always #5 clk = ~clk;

   pipe_stream_checker #(.DATA_W(16), .ERR_W(4), .THR_W(32), .SEED(32'h0000_0001)) u16 (
      .clk(clk), .reset_n(reset_n), .mode(mode), .throttle_set(throttle_set),
      .throttle_in_val(thr_in_val), .throttle_out_val(thr_out_val),
      .pipe_in_write(wr16), .pipe_in_data(din16), .pipe_in_ready(in_rdy16),
      .pipe_out_read(rd16), .pipe_out_data(dout16), .pipe_out_ready(out_rdy16),
`ifdef PIPE_STREAM_ERR_INJECT_EN
      .inject_err(inject_err),
`endif
      .error_count(err16), .first_err_valid(fev16), .first_err_exp(fexp16),
      .first_err_act(fact16), .words_in(win16), .words_out(wout16));

   pipe_stream_checker #(.DATA_W(64), .ERR_W(16), .THR_W(32), .SEED(32'h0000_0001)) u64 (
      .clk(clk), .reset_n(reset_n), .mode(mode), .throttle_set(throttle_set),
      .throttle_in_val(thr_in_val), .throttle_out_val(thr_out_val),
      .pipe_in_write(wr64), .pipe_in_data(din64), .pipe_in_ready(in_rdy64),
      .pipe_out_read(rd64), .pipe_out_data(dout64), .pipe_out_ready(out_rdy64),
`ifdef PIPE_STREAM_ERR_INJECT_EN
      .inject_err(inject_err),
`endif
      .error_count(err64), .first_err_valid(fev64), .first_err_exp(fexp64),
      .first_err_act(fact64), .words_in(win64), .words_out(wout64));

   // Reference sequence: successive states of the polynomial x^32+x^22+x^2+x+1,
   // new bit = xor of the state bits at exponents 32,22,2,1 (bit k-1 for x^k).
   function automatic void build_lfsr_seq();
      int unsigned taps [4] = '{32, 22, 2, 1};
      logic [31:0] s;
      logic fb;
      s = 32'h0000_0001;
      for (int n = 0; n <= 1100; n++) begin
         lseq[n] = s;
         fb = 1'b0;
         foreach (taps[t]) fb = fb ^ s[taps[t]-1];
         s = {s[30:0], fb};
      end
   endfunction

   function automatic logic [15:0] pat16(input logic [1:0] m, input int n);
      case (m)
         2'b01:   return lseq[n][15:0];
         2'b10:   return 16'(1) << (n % 16);
         default: return 16'(n);
      endcase
   endfunction

   function automatic logic [63:0] pat64(input logic [1:0] m, input int n);
      case (m)
         2'b01:   return {~lseq[n], lseq[n]};
         2'b10:   return 64'(1) << (n % 64);
         default: return 64'(n);
      endcase
   endfunction

   // one clock edge; inputs were set before the call, outputs are settled on return
   task automatic tick();
      @(negedge clk);
      rd16 = 1'b0; wr16 = 1'b0; rd64 = 1'b0; wr64 = 1'b0; throttle_set = 1'b0;
   endtask

   task automatic do_reset(input logic [1:0] m);
      mode = m;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      rd16 = 1'b1; wr16 = 1'b1; din16 = 16'h1234;
      do_reset(2'b00);
      vec++; if (dout16 !== 16'h0) begin miss++; $display("FAIL reset_dout: got %h want 0000", dout16); end
      vec++; if (err16 !== 4'h0) begin miss++; $display("FAIL reset_err: got %h want 0", err16); end
      vec++; if ({fev16, fexp16, fact16} !== 33'h0) begin miss++; $display("FAIL reset_first_err: got %b %h %h want zeros", fev16, fexp16, fact16); end
      vec++; if ({win16, wout16} !== 64'h0) begin miss++; $display("FAIL reset_words: got %0d %0d want 0 0", win16, wout16); end
      vec++; if ({in_rdy16, out_rdy16} !== 2'b00) begin miss++; $display("FAIL reset_ready: got %b want 00", {in_rdy16, out_rdy16}); end
      vec++; if (dout64 !== 64'h0) begin miss++; $display("FAIL reset_dout64: got %h want 0", dout64); end
      tick();
      vec++; if ({in_rdy16, out_rdy16} !== 2'b11) begin miss++; $display("FAIL reset_thr_ones: got %b want 11", {in_rdy16, out_rdy16}); end
   endtask

   task automatic test_counter_loopback();
      do_reset(2'b00);
      for (int i = 0; i < 16; i++) begin
         vec++; if (dout16 !== 16'(i)) begin miss++; $display("FAIL cnt_read%0d: got %h want %h", i, dout16, 16'(i)); end
         rd16 = 1'b1;
         tick();
      end
      for (int i = 0; i < 16; i++) begin
         wr16 = 1'b1; din16 = 16'(i);
         tick();
      end
      vec++; if (err16 !== 4'h0) begin miss++; $display("FAIL cnt_err: got %h want 0", err16); end
      vec++; if (win16 !== 32'd16 || wout16 !== 32'd16) begin miss++; $display("FAIL cnt_words: got %0d %0d want 16 16", win16, wout16); end
   endtask

   task automatic test_lfsr64();
      int bad = 0;
      do_reset(2'b01);
      vec++; if (dout64 !== 64'hFFFF_FFFE_0000_0001) begin miss++; $display("FAIL lfsr64_first: got %h want FFFFFFFE00000001", dout64); end
      for (int n = 0; n < 1000; n++) begin
         if (dout64 !== pat64(2'b01, n) && bad < 4) begin
            bad++; $display("FAIL lfsr64_word%0d: got %h want %h", n, dout64, pat64(2'b01, n));
         end
         if (dout64 !== pat64(2'b01, n)) miss++;
         vec++;
         rd64 = 1'b1; wr64 = 1'b1; din64 = pat64(2'b01, n);
         tick();
      end
      vec++; if (err64 !== 16'h0) begin miss++; $display("FAIL lfsr64_err: got %h want 0", err64); end
      vec++; if (win64 !== 32'd1000 || wout64 !== 32'd1000) begin miss++; $display("FAIL lfsr64_words: got %0d %0d want 1000 1000", win64, wout64); end
   endtask

   task automatic test_first_error();
      logic [15:0] w [8] = '{16'h0, 16'h1, 16'h2, 16'h3, 16'hBEEF, 16'h5, 16'h6, 16'h7};
      do_reset(2'b00);
      foreach (w[i]) begin
         wr16 = 1'b1; din16 = w[i];
         tick();
      end
      vec++; if (err16 !== 4'h1) begin miss++; $display("FAIL ferr_count: got %h want 1", err16); end
      vec++; if (fev16 !== 1'b1) begin miss++; $display("FAIL ferr_valid: got %b want 1", fev16); end
      vec++; if (fexp16 !== 16'h0004 || fact16 !== 16'hBEEF) begin miss++; $display("FAIL ferr_pair: got %h %h want 0004 BEEF", fexp16, fact16); end
   endtask

   task automatic test_saturation();
      do_reset(2'b00);
      for (int n = 0; n < 20; n++) begin
         wr16 = 1'b1; din16 = ~16'(n);
         tick();
         if (n == 13) begin
            vec++; if (err16 !== 4'hE) begin miss++; $display("FAIL sat_count14: got %h want E", err16); end
         end
      end
      vec++; if (err16 !== 4'hF) begin miss++; $display("FAIL sat_count: got %h want F", err16); end
      vec++; if (fexp16 !== 16'h0000 || fact16 !== 16'hFFFF) begin miss++; $display("FAIL sat_pair: got %h %h want 0000 FFFF", fexp16, fact16); end
      vec++; if (win16 !== 32'd20) begin miss++; $display("FAIL sat_words: got %0d want 20", win16); end
   endtask

   task automatic test_throttle();
      do_reset(2'b00);
      thr_out_val = 32'hAAAA_AAAA; thr_in_val = 32'h0; throttle_set = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) begin
         tick();
         vec++; if (out_rdy16 !== ((k % 2) == 0)) begin miss++; $display("FAIL thr_toggle%0d: got %b want %b", k, out_rdy16, (k % 2) == 0); end
         vec++; if (in_rdy16 !== 1'b0) begin miss++; $display("FAIL thr_in_zero%0d: got %b want 0", k, in_rdy16); end
      end
      thr_out_val = 32'h0; throttle_set = 1'b1;
      tick();
      for (int k = 0; k < 6; k++) begin
         tick();
         vec++; if (out_rdy16 !== 1'b0) begin miss++; $display("FAIL thr_out_zero%0d: got %b want 0", k, out_rdy16); end
      end
   endtask

   task automatic test_mid_reset();
      do_reset(2'b00);
      for (int i = 0; i < 7; i++) begin
         rd16 = 1'b1; wr16 = (i < 2); din16 = 16'h5555;
         tick();
      end
      vec++; if (dout16 !== 16'h0007 || err16 !== 4'h2) begin miss++; $display("FAIL mid_pre: got %h %h want 0007 2", dout16, err16); end
      rd16 = 1'b1; wr16 = 1'b1; din16 = 16'h1234; reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      vec++; if (dout16 !== 16'h0) begin miss++; $display("FAIL mid_dout: got %h want 0000", dout16); end
      vec++; if ({err16, fev16, fexp16, fact16} !== 37'h0) begin miss++; $display("FAIL mid_captures: got %h %b %h %h want zeros", err16, fev16, fexp16, fact16); end
      vec++; if ({win16, wout16} !== 64'h0) begin miss++; $display("FAIL mid_words: got %0d %0d want 0 0", win16, wout16); end
`ifdef PIPE_STREAM_ERR_INJECT_EN
      inject_err = 1'b1;
      tick();
      inject_err = 1'b0;
      rd16 = 1'b1;
      tick();
      vec++; if (dout16 !== 16'h0000) begin miss++; $display("FAIL inj_word1: got %h want 0000", dout16); end
      rd16 = 1'b1;
      tick();
      vec++; if (dout16 !== 16'h0002) begin miss++; $display("FAIL inj_word2: got %h want 0002", dout16); end
`else
      rd16 = 1'b1;
      tick();
      vec++; if (dout16 !== 16'h0001) begin miss++; $display("FAIL mid_resume: got %h want 0001", dout16); end
`endif
   endtask

   task automatic test_mode_change();
      do_reset(2'b00);
      rd16 = 1'b1; tick();
      rd16 = 1'b1; tick();
      wr16 = 1'b1; din16 = 16'h0; tick();
      wr16 = 1'b1; din16 = 16'h1; tick();
      // switch to walking-ones while reading and writing the old word 2
      mode = 2'b10; rd16 = 1'b1; wr16 = 1'b1; din16 = 16'h0002;
      tick();
      vec++; if (err16 !== 4'h0) begin miss++; $display("FAIL mchg_err: got %h want 0", err16); end
      vec++; if (dout16 !== 16'h0001) begin miss++; $display("FAIL mchg_word0: got %h want 0001", dout16); end
      vec++; if (win16 !== 32'd3 || wout16 !== 32'd3) begin miss++; $display("FAIL mchg_words: got %0d %0d want 3 3", win16, wout16); end
      rd16 = 1'b1; wr16 = 1'b1; din16 = 16'h0001;
      tick();
      vec++; if (dout16 !== 16'h0002 || err16 !== 4'h0) begin miss++; $display("FAIL mchg_next: got %h %h want 0002 0", dout16, err16); end
   endtask

   task automatic test_random();
      logic [1:0]  mq;
      int          on, inn, rn, wn;
      logic [3:0]  e;
      logic        fv;
      logic [15:0] fe, fa, ex, d;
      logic        r, w;
      int bad = 0;
      do_reset(2'b00);
      mq = 2'b00; on = 0; inn = 0; rn = 0; wn = 0; e = 0; fv = 0; fe = 0; fa = 0;
      for (int c = 0; c < 400; c++) begin
         vec++;
         if (dout16 !== pat16(mq, on)) begin
            miss++;
            if (bad < 4) begin bad++; $display("FAIL rand_dout%0d: got %h want %h", c, dout16, pat16(mq, on)); end
         end
         r = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         ex = pat16(mq, inn);
         d = ($urandom_range(0, 7) == 0) ? ex ^ 16'($urandom_range(1, 65535)) : ex;
         if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
         rd16 = r; wr16 = w; din16 = d;
         tick();
         if (w) begin
            if (d != ex) begin
               if (e != 4'hF) e = e + 4'd1;
               if (!fv) begin fv = 1'b1; fe = ex; fa = d; end
            end
            inn++; wn++;
         end
         if (r) begin on++; rn++; end
         if (mode != mq) begin inn = 0; on = 0; mq = mode; end
      end
      vec++; if (err16 !== e) begin miss++; $display("FAIL rand_err: got %h want %h", err16, e); end
      vec++; if ({fev16, fexp16, fact16} !== {fv, fe, fa}) begin miss++; $display("FAIL rand_first: got %b %h %h want %b %h %h", fev16, fexp16, fact16, fv, fe, fa); end
      vec++; if (win16 !== 32'(wn) || wout16 !== 32'(rn)) begin miss++; $display("FAIL rand_words: got %0d %0d want %0d %0d", win16, wout16, wn, rn); end
      mode = 2'b00;
   endtask

   initial begin
      build_lfsr_seq();
      @(negedge clk);
      test_reset();
      test_counter_loopback();
      test_lfsr64();
      test_first_error();
      test_saturation();
      test_throttle();
      test_mid_reset();
      test_mode_change();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
